// File: rtl/jk_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// jk_cmd_seq_if
//   Command channel into the JK command sequencer: a valid/ready handshake
//   carrying one {op, len} command per transfer.
//
//   Signals
//     cmd_valid  producer has a command on cmd_op/cmd_len
//     cmd_ready  sequencer FIFO can accept a command this cycle
//     cmd_op     00 hold, 01 clear, 10 set, 11 toggle
//     cmd_len    number of enabled flip-flop cycles (0 = no-op)
//
//   Modports
//     master  command producer
//     slave   the sequencer
// ---------------------------------------------------------------------------
interface jk_cmd_seq_if #(
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// ---------------------------------------------------------------------------
// jk_cmd_seq
//   Command sequencer sitting directly upstream of a JK flip-flop with
//   enable and active-high reset. Commands (hold/clear/set/toggle plus a
//   repeat count) are buffered in a small FIFO and replayed onto the
//   flip-flop's J/K/enable pins for exactly the requested number of enabled
//   cycles. A shadow model of the flip-flop output is kept and compared
//   against the fed-back q every cycle; any disagreement raises a sticky err.
//
//   Ports
//     clk      system clock, rising edge
//     reset    asynchronous reset, active-low
//     cmd      command channel (jk_cmd_seq_if.slave)
//     q_in     flip-flop q, fed back
//     J, K     flip-flop data inputs (non-zero only while running)
//     enable   flip-flop enable
//     ff_rst   flip-flop reset, active-high (held during reset and INIT)
//     busy     a command is running or just completing
//     done     one-cycle pulse at command completion
//     err      sticky q mismatch flag
//     level    FIFO occupancy
// ---------------------------------------------------------------------------
module jk_cmd_seq #(
  parameter int CNT_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  jk_cmd_seq_if.slave              cmd,
  input  logic                     q_in,
  output logic                     J,
  output logic                     K,
  output logic                     enable,
  output logic                     ff_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = CNT_W + 2;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  // Next flip-flop output for a given current q and JK opcode.
  function automatic logic jk_apply(input logic q, input logic [1:0] op);
    logic r;
    case (op)
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_len;

  assign full          = (level == LW'(DEPTH));
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  // Pop depends only on registered level, so a command written into an
  // empty FIFO cannot be popped on the same edge it arrives.
  assign pop           = (state == S_IDLE) && (level != '0);
  assign head          = mem[rd_ptr];
  assign head_op       = head[EW-1:CNT_W];
  assign head_len      = head[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_len};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Active command registers (datapath, loaded on pop)
  // -------------------------------------------------------------------------
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk) begin
    if (pop) begin
      op_r  <= head_op;
      cnt_r <= head_len;
    end else if (state == S_RUN) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Sequencing FSM with registered Moore outputs, shadow q model and check
  // -------------------------------------------------------------------------
  logic exp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_INIT;
      J      <= 1'b0;
      K      <= 1'b0;
      enable <= 1'b0;
      ff_rst <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      exp_q  <= 1'b0;
      err    <= 1'b0;
    end else begin
      // INIT is excluded: the flip-flop is still being cleared there.
      if ((state != S_INIT) && (q_in != exp_q)) begin
        err <= 1'b1;
      end

      case (state)
        S_INIT: begin
          exp_q  <= 1'b0;
          ff_rst <= 1'b0;
          state  <= S_IDLE;
        end

        S_IDLE: begin
          if (pop) begin
            busy <= 1'b1;
            if (head_len == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              enable <= 1'b1;
              J      <= head_op[1];
              K      <= head_op[0];
              state  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          exp_q <= jk_apply(exp_q, op_r);
          // Leaving on cnt_r==1 keeps enable high for exactly len cycles.
          if (cnt_r == CNT_W'(1)) begin
            enable <= 1'b0;
            J      <= 1'b0;
            K      <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state  <= S_INIT;
          J      <= 1'b0;
          K      <= 1'b0;
          enable <= 1'b0;
          ff_rst <= 1'b1;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
